// File: rtl/gain_ramp.sv
// Multi-channel gain stage with a rate-limited gain ramp toward a target (fade-in after reset, mute fades).
// Two-stage pipeline: registered products, then round-half-up with per-channel saturation.
module gain_ramp #(
  parameter int DWIDTH       = 16,
  parameter int CHANNELS     = 2,
  parameter int GAIN_W       = 10,
  parameter int GAIN_FRAC    = 8,
  parameter int STEP         = 1,
  parameter int RESET_TARGET = 2 ** GAIN_FRAC
) (
  input  logic                         clk_i,
  input  logic                         srst_i,
  input  logic [CHANNELS*DWIDTH-1:0]   data_i,
  input  logic                         data_valid_i,
  input  logic [GAIN_W-1:0]            gain_i,
  input  logic                         gain_load_i,
  input  logic                         mute_i,
  output logic [CHANNELS*DWIDTH-1:0]   data_o,
  output logic                         data_valid_o,
  output logic                         sat_o,
  output logic [GAIN_W-1:0]            gain_o,
  output logic                         busy_o
);

  localparam int PW = DWIDTH + GAIN_W + 1;
  localparam logic [GAIN_W:0]          STEP_X = (GAIN_W + 1)'(STEP);
  localparam logic [GAIN_W-1:0]        RST_TGT = GAIN_W'(RESET_TARGET);
  localparam logic signed [PW-1:0]     HALF = PW'(64'sd1 <<< (GAIN_FRAC - 1));
  localparam logic signed [PW-1:0]     MAXV = PW'((64'sd1 <<< (DWIDTH - 1)) - 64'sd1);
  localparam logic signed [PW-1:0]     MINV = PW'(-(64'sd1 <<< (DWIDTH - 1)));

  logic [GAIN_W-1:0] gain;
  logic [GAIN_W-1:0] target;
  logic [GAIN_W-1:0] step_target;
  logic [GAIN_W-1:0] next_gain;
  logic [GAIN_W:0]   diff;
  logic              valid_s1;
  logic              valid_s2;

  logic signed [PW-1:0]        prod_c [CHANNELS];
  logic signed [PW-1:0]        prod_q [CHANNELS];
  logic [CHANNELS*DWIDTH-1:0]  sat_data;
  logic [CHANNELS-1:0]         clip;

  assign gain_o       = gain;
  assign data_valid_o = valid_s2;
  assign busy_o       = (gain != (mute_i ? '0 : target));

  // A load coinciding with a frame steers that frame's gain step, so look through the target register.
  assign step_target = mute_i ? '0 : (gain_load_i ? gain_i : target);

  always_comb begin
    next_gain = gain;
    diff      = '0;
    if (step_target > gain) begin
      diff      = {1'b0, step_target} - {1'b0, gain};
      next_gain = (diff > STEP_X) ? gain + STEP_X[GAIN_W-1:0] : step_target;
    end else if (step_target < gain) begin
      diff      = {1'b0, gain} - {1'b0, step_target};
      next_gain = (diff > STEP_X) ? gain - STEP_X[GAIN_W-1:0] : step_target;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic signed [DWIDTH-1:0] sample;
    logic signed [PW-1:0]     rounded;
    logic                     clip_hi;
    logic                     clip_lo;

    assign sample    = data_i[k*DWIDTH +: DWIDTH];
    // Gain is zero-extended so the full-width product never truncates.
    assign prod_c[k] = PW'(sample) * $signed({{(PW-GAIN_W){1'b0}}, gain});
    assign rounded   = (prod_q[k] + HALF) >>> GAIN_FRAC;
    assign clip_hi   = (rounded > MAXV);
    assign clip_lo   = (rounded < MINV);
    assign clip[k]   = clip_hi | clip_lo;
    assign sat_data[k*DWIDTH +: DWIDTH] = clip_hi ? MAXV[DWIDTH-1:0] :
                                          clip_lo ? MINV[DWIDTH-1:0] :
                                                    rounded[DWIDTH-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      gain     <= '0;
      target   <= RST_TGT;
      valid_s1 <= 1'b0;
      valid_s2 <= 1'b0;
      data_o   <= '0;
      sat_o    <= 1'b0;
    end else begin
      if (gain_load_i) target <= gain_i;
      if (data_valid_i) gain <= next_gain;
      valid_s1 <= data_valid_i;
      valid_s2 <= valid_s1;
      if (valid_s1) begin
        data_o <= sat_data;
        sat_o  <= |clip;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (data_valid_i) begin
      for (int k = 0; k < CHANNELS; k++) prod_q[k] <= prod_c[k];
    end
  end

endmodule
